// File: rtl/stage_join_pkg.sv
// Shared definitions for the per-stage PHV/VLAN join.
package stage_join_pkg;

    // Default datapath widths.
    localparam int unsigned DEF_PHV_LEN      = 1024;
    localparam int unsigned DEF_VLANID_WIDTH = 12;

    // Age-timeout FSM state encoding.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } join_state_t;

endpackage

// File: rtl/stage_join_fifo.sv
// Generic synchronous FIFO with registered occupancy; head is visible the cycle after the write.
module stage_join_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_BITS = 2
) (
    input  logic             axis_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  do_wr;
    logic                  do_rd;

    // Guard against overflow/underflow even if a caller misbehaves.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    assign empty = (count == '0);
    assign full  = (count == (DEPTH_BITS + 1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge axis_clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge axis_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stage_phv_vlan_join.sv
// Pairs the PHV and VLAN-ID streams in order, flags tag mismatches and drops stale lone heads.
module stage_phv_vlan_join
    import stage_join_pkg::*;
#(
    parameter int unsigned PHV_LEN              = DEF_PHV_LEN,
    parameter int unsigned C_VLANID_WIDTH       = DEF_VLANID_WIDTH,
    parameter int unsigned VLAN_OFF             = 129,
    parameter int unsigned PHV_FIFO_DEPTH_BITS  = 2,
    parameter int unsigned VLAN_FIFO_DEPTH_BITS = 2,
    parameter int unsigned TIMEOUT_CYCLES       = 255,
    parameter int unsigned CNT_WIDTH            = 16
) (
    input  logic                      axis_clk,
    input  logic                      reset,
    input  logic [PHV_LEN-1:0]        phv_in,
    input  logic                      phv_in_valid,
    output logic                      phv_in_ready,
    input  logic [C_VLANID_WIDTH-1:0] vlan_in,
    input  logic                      vlan_in_valid,
    output logic                      vlan_in_ready,
    input  logic                      check_en,
    output logic [PHV_LEN-1:0]        phv_out,
    output logic [C_VLANID_WIDTH-1:0] vlan_out,
    output logic                      out_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_WIDTH-1:0]      mismatch_cnt,
    output logic [CNT_WIDTH-1:0]      timeout_cnt
);

    localparam bit          TMO_EN  = (TIMEOUT_CYCLES != 0);
    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TMO_LAST =
        TIMER_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [PHV_LEN-1:0]        phv_head;
    logic [C_VLANID_WIDTH-1:0] vlan_head;
    logic                      phv_empty;
    logic                      phv_full;
    logic                      vlan_empty;
    logic                      vlan_full;
    logic                      phv_wr;
    logic                      vlan_wr;
    logic                      phv_rd;
    logic                      vlan_rd;
    logic                      pair_go;
    logic                      drop_go;
    logic                      lone_head;
    logic                      tag_mismatch;

    join_state_t               state;
    logic [TIMER_W-1:0]        timer;

    // Ready depends only on registered occupancy, never on valid.
    assign phv_in_ready  = ~phv_full;
    assign vlan_in_ready = ~vlan_full;
    assign phv_wr        = phv_in_valid & phv_in_ready;
    assign vlan_wr       = vlan_in_valid & vlan_in_ready;

    assign lone_head    = phv_empty ^ vlan_empty;
    assign pair_go      = ~phv_empty & ~vlan_empty & (~out_valid | out_ready);
    // A drop only fires if the partner still has not shown up; otherwise pairing wins.
    assign drop_go      = (state == StDrop) & lone_head;
    assign phv_rd       = pair_go | (drop_go & ~phv_empty);
    assign vlan_rd      = pair_go | (drop_go & ~vlan_empty);
    assign tag_mismatch = check_en & (phv_head[VLAN_OFF +: C_VLANID_WIDTH] != vlan_head);

    stage_join_fifo #(
        .WIDTH      (PHV_LEN),
        .DEPTH_BITS (PHV_FIFO_DEPTH_BITS)
    ) u_phv_fifo (
        .axis_clk (axis_clk),
        .reset    (reset),
        .din      (phv_in),
        .wr_en    (phv_wr),
        .rd_en    (phv_rd),
        .dout     (phv_head),
        .empty    (phv_empty),
        .full     (phv_full)
    );

    stage_join_fifo #(
        .WIDTH      (C_VLANID_WIDTH),
        .DEPTH_BITS (VLAN_FIFO_DEPTH_BITS)
    ) u_vlan_fifo (
        .axis_clk (axis_clk),
        .reset    (reset),
        .din      (vlan_in),
        .wr_en    (vlan_wr),
        .rd_en    (vlan_rd),
        .dout     (vlan_head),
        .empty    (vlan_empty),
        .full     (vlan_full)
    );

    // Output register: load on pair_go, hold while stalled, clear valid once consumed.
    always_ff @(posedge axis_clk or posedge reset) begin
        if (reset) begin
            phv_out   <= '0;
            vlan_out  <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
        end else if (pair_go) begin
            phv_out   <= phv_head;
            vlan_out  <= vlan_head;
            out_err   <= tag_mismatch;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of pairs emitted with a tag mismatch.
    always_ff @(posedge axis_clk or posedge reset) begin
        if (reset) begin
            mismatch_cnt <= '0;
        end else if (pair_go && tag_mismatch && !(&mismatch_cnt)) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
        end
    end

    // Age FSM: only a lone head ages, so output backpressure never counts as a timeout.
    always_ff @(posedge axis_clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            timer       <= '0;
            timeout_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    timer <= '0;
                    if (lone_head && TMO_EN) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (!lone_head) begin
                        timer <= '0;
                        state <= StIdle;
                    end else if (timer == TMO_LAST) begin
                        state <= StDrop;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                StDrop: begin
                    timer <= '0;
                    state <= StIdle;
                    if (drop_go && !(&timeout_cnt)) begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                default: begin
                    timer <= '0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_phv_vlan_join.sv
// Scoreboard bench for stage_phv_vlan_join with a short timeout.
module tb_stage_phv_vlan_join;

    localparam int unsigned PL   = 1024;
    localparam int unsigned VW   = 12;
    localparam int unsigned VOFF = 129;
    localparam int unsigned CW   = 16;

    logic          axis_clk;
    logic          reset;
    logic [PL-1:0] phv_in;
    logic          phv_in_valid;
    logic          phv_in_ready;
    logic [VW-1:0] vlan_in;
    logic          vlan_in_valid;
    logic          vlan_in_ready;
    logic          check_en;
    logic [PL-1:0] phv_out;
    logic [VW-1:0] vlan_out;
    logic          out_err;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] mismatch_cnt;
    logic [CW-1:0] timeout_cnt;

    int checks = 0;
    int errors = 0;

    // Pending inputs not yet paired, and the expected output stream.
    logic [PL-1:0] phv_q[$];
    logic [VW-1:0] vlan_q[$];
    logic [PL-1:0] exp_phv_q[$];
    logic [VW-1:0] exp_vlan_q[$];
    logic          exp_err_q[$];

    stage_phv_vlan_join #(
        .PHV_LEN              (PL),
        .C_VLANID_WIDTH       (VW),
        .VLAN_OFF             (VOFF),
        .PHV_FIFO_DEPTH_BITS  (2),
        .VLAN_FIFO_DEPTH_BITS (2),
        .TIMEOUT_CYCLES       (8),
        .CNT_WIDTH            (CW)
    ) dut (
        .axis_clk      (axis_clk),
        .reset         (reset),
        .phv_in        (phv_in),
        .phv_in_valid  (phv_in_valid),
        .phv_in_ready  (phv_in_ready),
        .vlan_in       (vlan_in),
        .vlan_in_valid (vlan_in_valid),
        .vlan_in_ready (vlan_in_ready),
        .check_en      (check_en),
        .phv_out       (phv_out),
        .vlan_out      (vlan_out),
        .out_err       (out_err),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .mismatch_cnt  (mismatch_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic check_val(input string tag, input logic [PL-1:0] got, input logic [PL-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PL-1:0] mk_phv(input logic [VW-1:0] tag, input int unsigned salt);
        logic [PL-1:0] p;
        for (int i = 0; i < PL / 32; i++) begin
            p[i*32 +: 32] = salt * 32'h9E37_79B1 + i;
        end
        p[VOFF +: VW] = tag;
        return p;
    endfunction

    // In-order pairing model; error flag uses check_en as it stands when the pair forms.
    task automatic model_pair();
        logic [PL-1:0] p;
        logic [VW-1:0] v;
        while (phv_q.size() > 0 && vlan_q.size() > 0) begin
            p = phv_q.pop_front();
            v = vlan_q.pop_front();
            exp_phv_q.push_back(p);
            exp_vlan_q.push_back(v);
            exp_err_q.push_back(check_en && (p[VOFF +: VW] != v));
        end
    endtask

    // Drive one cycle of input from a negedge; record what the DUT accepts.
    task automatic send(input logic dp, input logic [PL-1:0] p, input logic dv,
                        input logic [VW-1:0] v);
        phv_in        = p;
        phv_in_valid  = dp;
        vlan_in       = v;
        vlan_in_valid = dv;
        if (dp && phv_in_ready) phv_q.push_back(p);
        if (dv && vlan_in_ready) vlan_q.push_back(v);
        model_pair();
        @(negedge axis_clk);
        phv_in_valid  = 1'b0;
        vlan_in_valid = 1'b0;
    endtask

    task automatic flush_model();
        phv_q.delete();
        vlan_q.delete();
        exp_phv_q.delete();
        exp_vlan_q.delete();
        exp_err_q.delete();
    endtask

    // Output monitor: every accepted output beat is popped from the scoreboard.
    always begin
        @(negedge axis_clk);
        #1;
        if (!reset && out_valid && out_ready) begin
            if (exp_phv_q.size() == 0) begin
                check_val("unexpected_out", PL'(out_valid), '0);
            end else begin
                check_val("sb_phv", phv_out, exp_phv_q.pop_front());
                check_val("sb_vlan", PL'(vlan_out), PL'(exp_vlan_q.pop_front()));
                check_val("sb_err", PL'(out_err), PL'(exp_err_q.pop_front()));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen_valid;
        reset         = 1'b1;
        phv_in        = '0;
        phv_in_valid  = 1'b0;
        vlan_in       = '0;
        vlan_in_valid = 1'b0;
        check_en      = 1'b1;
        out_ready     = 1'b1;
        #1;
        check_val("rst_valid", PL'(out_valid), '0);
        check_val("rst_phv", phv_out, '0);
        check_val("rst_vlan", PL'(vlan_out), '0);
        check_val("rst_err", PL'(out_err), '0);
        check_val("rst_mm_cnt", PL'(mismatch_cnt), '0);
        check_val("rst_to_cnt", PL'(timeout_cnt), '0);
        repeat (2) @(negedge axis_clk);
        reset = 1'b0;
        @(negedge axis_clk);
        check_val("rdy_phv", PL'(phv_in_ready), PL'(1));
        check_val("rdy_vlan", PL'(vlan_in_ready), PL'(1));

        // Matched pair in the same cycle: valid two cycles after the drive cycle.
        send(1'b1, mk_phv(12'h005, 1), 1'b1, 12'h005);
        #1 check_val("lat_c1", PL'(out_valid), '0);
        @(negedge axis_clk);
        #1 check_val("lat_c2", PL'(out_valid), PL'(1));
        check_val("lat_vlan", PL'(vlan_out), PL'(12'h005));
        check_val("lat_err", PL'(out_err), '0);
        repeat (3) @(negedge axis_clk);
        check_val("mm_cnt0", PL'(mismatch_cnt), '0);

        // Tag mismatch with checking on, then off.
        send(1'b1, mk_phv(12'h005, 2), 1'b1, 12'h007);
        repeat (3) @(negedge axis_clk);
        check_val("mm_cnt1", PL'(mismatch_cnt), PL'(1));
        check_en = 1'b0;
        send(1'b1, mk_phv(12'h005, 3), 1'b1, 12'h007);
        repeat (3) @(negedge axis_clk);
        check_val("mm_cnt_off", PL'(mismatch_cnt), PL'(1));
        check_en = 1'b1;

        // Backpressure: one pair held at the output, four queued behind it.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, mk_phv(12'h100 + 12'(i), 10 + i), 1'b1, 12'h100 + 12'(i));
        end
        #1;
        check_val("bp_phv_full", PL'(phv_in_ready), '0);
        check_val("bp_vlan_full", PL'(vlan_in_ready), '0);
        check_val("bp_held", PL'(out_valid), PL'(1));
        check_val("bp_held_vlan", PL'(vlan_out), PL'(12'h100));
        repeat (30) @(negedge axis_clk);
        check_val("bp_no_timeout", PL'(timeout_cnt), '0);
        check_val("bp_still_held", PL'(out_valid), PL'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check_val("bp_stream", PL'(out_valid), PL'(1));
            check_val("bp_order", PL'(vlan_out), PL'(12'h100 + 12'(i)));
            @(negedge axis_clk);
        end
        #1 check_val("bp_drained", PL'(out_valid), '0);
        check_val("bp_mm_cnt", PL'(mismatch_cnt), PL'(1));
        repeat (2) @(negedge axis_clk);

        // Lone PHV ages out and is dropped without producing output.
        send(1'b1, mk_phv(12'h011, 20), 1'b0, '0);
        seen_valid = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge axis_clk);
            if (out_valid) seen_valid++;
        end
        check_val("to_cnt1", PL'(timeout_cnt), PL'(1));
        check_val("to_no_out", PL'(seen_valid), '0);
        if (phv_q.size() > 0) void'(phv_q.pop_front());
        // A VLAN sent afterwards pairs with the next PHV.
        send(1'b0, '0, 1'b1, 12'h022);
        send(1'b1, mk_phv(12'h022, 21), 1'b0, '0);
        repeat (4) @(negedge axis_clk);
        check_val("to_after_pair", PL'(exp_phv_q.size()), '0);
        repeat (4) @(negedge axis_clk);

        // Partner arrives exactly as the FSM enters DROP: pairing wins.
        send(1'b1, mk_phv(12'h033, 30), 1'b0, '0);
        repeat (8) @(negedge axis_clk);
        send(1'b0, '0, 1'b1, 12'h033);
        repeat (4) @(negedge axis_clk);
        check_val("edge_to_cnt", PL'(timeout_cnt), PL'(1));
        check_val("edge_paired", PL'(exp_phv_q.size()), '0);
        repeat (12) @(negedge axis_clk);
        check_val("edge_quiet_to", PL'(timeout_cnt), PL'(1));

        // Reset mid-burst with output held and entries queued.
        out_ready = 1'b0;
        send(1'b1, mk_phv(12'h040, 40), 1'b1, 12'h041);
        send(1'b1, mk_phv(12'h042, 41), 1'b1, 12'h042);
        send(1'b1, mk_phv(12'h043, 42), 1'b1, 12'h043);
        check_val("pre_rst_valid", PL'(out_valid), PL'(1));
        #2 reset = 1'b1;
        #1;
        check_val("arst_valid", PL'(out_valid), '0);
        check_val("arst_phv", phv_out, '0);
        check_val("arst_vlan", PL'(vlan_out), '0);
        check_val("arst_err", PL'(out_err), '0);
        check_val("arst_mm_cnt", PL'(mismatch_cnt), '0);
        check_val("arst_to_cnt", PL'(timeout_cnt), '0);
        flush_model();
        @(negedge axis_clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check_val("post_rst_rdy_phv", PL'(phv_in_ready), PL'(1));
        check_val("post_rst_rdy_vlan", PL'(vlan_in_ready), PL'(1));
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge axis_clk);
            if (out_valid) seen_valid++;
        end
        check_val("no_stale_pair", PL'(seen_valid), '0);
        check_val("post_rst_to_cnt", PL'(timeout_cnt), '0);

        // Traffic still flows after reset.
        send(1'b1, mk_phv(12'h055, 50), 1'b1, 12'h055);
        repeat (4) @(negedge axis_clk);
        check_val("sb_empty", PL'(exp_phv_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
